// File: rtl/sonic_decrypt_64x128.sv
// SONIC-64/128 iterative block decryptor.
// A 128-bit key is expanded once into 19 32-bit round keys (one key-schedule
// step per cycle). Each ciphertext block then runs through the inverse round,
// one round per cycle, using the round keys in reverse order.
// Round primitive (Feistel on two 32-bit halves):
//   F(r, k)        = (rotl(r,5) + k) ^ rotl(r,8)
//   rnd({l,r}, k)  = {r, l ^ F(r,k)}
//   inv({a,b}, k)  = {b ^ F(a,k), a}     so inv(rnd(x,k),k) == x
// Key schedule step:
//   ks(K) = rotl(K,61) ^ {32'hB7E15163, 96'h0}
module sonic_decrypt_64x128 (
    input  logic         clk,
    input  logic         resetn,
    input  logic [127:0] key,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [63:0]  in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [63:0]  out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int NKS     = 9;
    localparam int NROUNDS = 2 * NKS + 1;

    typedef enum logic [2:0] {
        S_NOKEY,
        S_EXPAND,
        S_READY,
        S_RUN,
        S_DONE
    } state_t;

    // Round function core shared by the inverse round.
    function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [31:0] k);
        logic [31:0] r5;
        logic [31:0] r8;
        r5 = {r[26:0], r[31:27]};
        r8 = {r[23:0], r[31:24]};
        return (r5 + k) ^ r8;
    endfunction

    // Undo one Feistel round: the left half of the input is the old right half.
    function automatic logic [63:0] inv_fn(input logic [63:0] x, input logic [31:0] k);
        return {x[31:0] ^ f_fn(x[63:32], k), x[63:32]};
    endfunction

    // One key-schedule iteration.
    function automatic logic [127:0] ks_fn(input logic [127:0] kk);
        return {kk[66:0], kk[127:67]} ^ {32'hB7E15163, 96'h0};
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   kreg_q, kreg_d;
    logic [3:0]     j_q, j_d;
    logic [63:0]    dreg_q, dreg_d;
    logic [4:0]     rc_q, rc_d;
    logic [63:0]    out_q, out_d;
    logic           out_valid_q, out_valid_d;

    logic           rk_load0;
    logic           rk_pair;
    logic [127:0]   ks_out;
    logic [31:0]    rk_rd [NROUNDS];
    logic [31:0]    rk_cur;
    logic [63:0]    inv_out;

    assign ks_out  = ks_fn(kreg_q);
    assign rk_cur  = rk_rd[rc_q];
    assign inv_out = inv_fn(dreg_q, rk_cur);

    // Round-key file: entry 0 comes straight from the key, entries 2j-1/2j
    // from the j-th key-schedule output. Not reset; state says whether it is valid.
    genvar gi;
    generate
        for (gi = 0; gi < NROUNDS; gi++) begin : g_rk
            logic [31:0] rk_q;
            if (gi == 0) begin : g_k0
                // Entry 0 is loaded on the key handshake.
                always_ff @(posedge clk) begin
                    if (rk_load0) rk_q <= key[127:96];
                end
            end else if ((gi % 2) == 1) begin : g_odd
                // Odd entries take the upper word of the j-th schedule output.
                always_ff @(posedge clk) begin
                    if (rk_pair && (j_q == 4'((gi + 1) / 2))) rk_q <= ks_out[127:96];
                end
            end else begin : g_even
                // Even entries take the next word of the same schedule output.
                always_ff @(posedge clk) begin
                    if (rk_pair && (j_q == 4'(gi / 2))) rk_q <= ks_out[95:64];
                end
            end
            assign rk_rd[gi] = rk_q;
        end
    endgenerate

    // Next-state and datapath decisions for the controller.
    always_comb begin
        state_d     = state_q;
        kreg_d      = kreg_q;
        j_d         = j_q;
        dreg_d      = dreg_q;
        rc_d        = rc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        rk_load0    = 1'b0;
        rk_pair     = 1'b0;
        case (state_q)
            S_NOKEY: begin
                if (key_valid) begin
                    kreg_d   = key;
                    rk_load0 = 1'b1;
                    j_d      = 4'd1;
                    state_d  = S_EXPAND;
                end
            end
            S_EXPAND: begin
                kreg_d  = ks_out;
                rk_pair = 1'b1;
                j_d     = j_q + 4'd1;
                if (j_q == 4'(NKS)) state_d = S_READY;
            end
            S_READY: begin
                // A key offer takes priority over a ciphertext offer.
                if (key_valid) begin
                    kreg_d   = key;
                    rk_load0 = 1'b1;
                    j_d      = 4'd1;
                    state_d  = S_EXPAND;
                end else if (in_valid) begin
                    dreg_d  = in;
                    rc_d    = 5'(NROUNDS - 1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                dreg_d = inv_out;
                if (rc_q == 5'd0) begin
                    out_d       = inv_out;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    rc_d = rc_q - 5'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_READY;
                end
            end
            default: begin
                state_d     = S_NOKEY;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Controller and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_NOKEY;
            kreg_q      <= '0;
            j_q         <= '0;
            dreg_q      <= '0;
            rc_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kreg_q      <= kreg_d;
            j_q         <= j_d;
            dreg_q      <= dreg_d;
            rc_q        <= rc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign key_ready = (state_q == S_NOKEY) || (state_q == S_READY);
    assign in_ready  = (state_q == S_READY) && !key_valid;
    assign busy      = (state_q == S_EXPAND) || (state_q == S_RUN);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sonic_decrypt_64x128.sv
// Scoreboard bench for sonic_decrypt_64x128. Plaintexts are encrypted by a
// forward reference model (key schedule + forward rounds); the monitor expects
// the decryptor to return each plaintext in order, 19 edges after its handshake.
module tb_sonic_decrypt_64x128;

    logic         clk = 1'b0;
    logic         resetn;
    logic [127:0] key;
    logic         key_valid;
    logic         key_ready;
    logic [63:0]  in;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    sonic_decrypt_64x128 dut (
        .clk       (clk),
        .resetn    (resetn),
        .key       (key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] pt;
        int          hs;
    } exp_t;
    exp_t sb[$];

    logic [31:0] model_rk [19];
    bit          spacing_chk = 1'b0;
    int          last_rise   = -1;
    logic        prev_ov     = 1'b0;
    int          nxfer       = 0;

    // ---------------- reference model (forward direction) ----------------
    function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [31:0] k);
        return ({r[26:0], r[31:27]} + k) ^ {r[23:0], r[31:24]};
    endfunction

    function automatic logic [63:0] rnd_ref(input logic [63:0] x, input logic [31:0] k);
        return {x[31:0], x[63:32] ^ f_ref(x[31:0], k)};
    endfunction

    function automatic logic [127:0] ks_ref(input logic [127:0] kk);
        return {kk[66:0], kk[127:67]} ^ {32'hB7E15163, 96'h0};
    endfunction

    task automatic model_set_key(input logic [127:0] k);
        logic [127:0] kk;
        kk = k;
        model_rk[0] = kk[127:96];
        for (int j = 1; j <= 9; j++) begin
            kk = ks_ref(kk);
            model_rk[2*j-1] = kk[127:96];
            model_rk[2*j]   = kk[95:64];
        end
    endtask

    function automatic logic [63:0] enc_ref(input logic [63:0] pt);
        logic [63:0] x;
        x = pt;
        for (int i = 0; i < 19; i++) x = rnd_ref(x, model_rk[i]);
        return x;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s act=timeout exp=event", name);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_ov   = 1'b0;
                last_rise = -1;
            end else begin
                if (out_valid && !prev_ov && sb.size() > 0) begin
                    chk("latency", 64'(cyc - sb[0].hs), 64'd19);
                    if (spacing_chk && last_rise >= 0)
                        chk("spacing", 64'(cyc - last_rise), 64'd21);
                    last_rise = cyc;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out act=%h exp=none", out);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("plaintext", out, e.pt);
                        nxfer++;
                        $display("xfer %0d cyc=%0d out=%h exp=%h", nxfer, cyc, out, e.pt);
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    // ---------------- drivers ----------------
    // Called just after a posedge; returns #1 after the key handshake edge.
    task automatic key_handshake(input logic [127:0] k);
        bit ok;
        ok = 1'b0;
        key = k;
        key_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (key_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("key_ready_wait");
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        model_set_key(k);
    endtask

    // Counts busy cycles of the expansion that just started.
    task automatic expand_wait();
        int cnt;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
        chk("expand_busy_cycles", 64'(cnt), 64'd9);
        chk("ready_after_expand", {63'd0, key_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_handshake(k);
        expand_wait();
    endtask

    task automatic send_pt(input logic [63:0] pt);
        bit ok;
        exp_t e;
        ok = 1'b0;
        in = enc_ref(pt);
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("in_ready_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.pt = pt;
        e.hs = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0]  pt;
        logic [63:0]  held;
        logic [127:0] ka;
        logic [127:0] kb;
        int           badcyc;

        resetn    = 1'b0;
        key       = '0;
        key_valid = 1'b0;
        in        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_key_ready", {63'd0, key_ready}, 64'd1);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // 1: all-zero key and plaintext
        load_key(128'h0);
        send_pt(64'h0);
        drain();

        // 2: back-to-back random blocks, 21-cycle spacing
        load_key(128'h0123456789ABCDEF_FEDCBA9876543210);
        spacing_chk = 1'b1;
        last_rise   = -1;
        for (int i = 0; i < 8; i++) send_pt({$urandom, $urandom});
        drain();
        spacing_chk = 1'b0;

        // 3: output held while out_ready is low; nothing accepted in DONE
        out_ready = 1'b0;
        pt = {$urandom, $urandom};
        send_pt(pt);
        begin
            bit ok;
            ok = 1'b0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (out_valid) begin ok = 1'b1; break; end
            end
            if (!ok) fail_now("done_wait");
        end
        held      = out;
        in        = {$urandom, $urandom};
        in_valid  = 1'b1;
        key       = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        badcyc    = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out !== held || !out_valid || in_ready || key_ready || busy) badcyc++;
        end
        chk("done_hold_bad_cycles", 64'(badcyc), 64'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        key_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("after_done_ready", {62'd0, key_ready, out_valid}, 64'd2);
        chk("out_keeps_last", out, pt);
        @(posedge clk);
        #1;

        // 4: simultaneous key and ciphertext offer in READY
        ka = {$urandom, $urandom, $urandom, $urandom};
        key       = ka;
        key_valid = 1'b1;
        in        = {$urandom, $urandom};
        in_valid  = 1'b1;
        @(negedge clk);
        chk("both_in_ready", {63'd0, in_ready}, 64'd0);
        chk("both_key_ready", {63'd0, key_ready}, 64'd1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        in_valid  = 1'b0;
        model_set_key(ka);
        expand_wait();
        send_pt({$urandom, $urandom});
        drain();

        // 5a: asynchronous reset in the middle of RUN (rc = 7)
        send_pt({$urandom, $urandom});
        repeat (11) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        void'(sb.pop_front());
        chk("run_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("run_rst_out", out, 64'd0);
        chk("run_rst_busy", {63'd0, busy}, 64'd0);
        chk("run_rst_key_ready", {63'd0, key_ready}, 64'd1);
        #4;
        resetn   = 1'b1;
        in       = {$urandom, $urandom};
        in_valid = 1'b1;
        badcyc   = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (busy || in_ready || out_valid || !key_ready) badcyc++;
        end
        chk("nokey_ignores_in", 64'(badcyc), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // 5b: asynchronous reset in the middle of EXPAND (j = 4)
        key_handshake({$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("exp_rst_busy", {63'd0, busy}, 64'd0);
        chk("exp_rst_key_ready", {63'd0, key_ready}, 64'd1);
        chk("exp_rst_in_ready", {63'd0, in_ready}, 64'd0);
        #4;
        resetn   = 1'b1;
        in       = {$urandom, $urandom};
        in_valid = 1'b1;
        badcyc   = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (busy || in_ready || out_valid) badcyc++;
        end
        chk("nokey_ignores_in2", 64'(badcyc), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // 6: key change between blocks
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        load_key(ka);
        send_pt({$urandom, $urandom});
        drain();
        load_key(kb);
        send_pt({$urandom, $urandom});
        send_pt({$urandom, $urandom});
        drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sonic_decrypt_64x128.md
Name: sonic_decrypt_64x128

Overview:
Iterative SONIC-64/128 block decryptor. It is the inverse of the fully unrolled sonic_encrypt_64x128 datapath. It expands a 128-bit key once into 19 round keys using the forward sonic_key_schedule_64x128, then applies sonic_round_inv_64x128 once per cycle in reverse key order. It sits on the read/return side of the memory-encryption path, with valid/ready handshakes on the key, ciphertext and plaintext interfaces.

Parameters:
NROUNDS, 19, number of cipher rounds; fixed, must equal 2*NKS+1.
NKS, 9, key-schedule iterations; fixed.

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
key  input  128  secret key
key_valid  input  1  key offered
key_ready  output  1  key can be accepted
in  input  64  ciphertext
in_valid  input  1  ciphertext offered
in_ready  output  1  ciphertext can be accepted
out  output  64  plaintext
out_valid  output  1  plaintext valid
out_ready  input  1  plaintext consumed
busy  output  1  expansion or decryption in progress

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on resetn. On reset: state NOKEY, out=0, out_valid=0, busy=0. Round-key file is not reset; its validity is tracked by state only.
- Round-key map (K0 = key, Kj = ks(K(j-1))):
  - RK[0] = K0[127:96]
  - RK[2j-1] = Kj[127:96], for j = 1..9
  - RK[2j] = Kj[95:64], for j = 1..9
- Decrypt computes pt = inv(RK[0], ... inv(RK[18], ct)).
- Required property: inv(rnd(x, rk), rk) == x.
- FSM states: NOKEY, EXPAND, READY, RUN, DONE.
- key_ready = (state==NOKEY) | (state==READY).
- in_ready = (state==READY) & ~key_valid. The key wins on a simultaneous offer; in is not accepted that cycle.
- busy = (state==EXPAND) | (state==RUN).
- NOKEY:
  - Key handshake: kreg<=key, RK[0]<=key[127:96], j<=1, go to EXPAND.
  - in_valid is ignored.
- EXPAND (exactly 9 cycles):
  - Each cycle: kreg<=ks(kreg), RK[2j-1]<=ks(kreg)[127:96], RK[2j]<=ks(kreg)[95:64], j<=j+1.
  - After j==9 is written, go to READY. Key handshake to READY takes 9 edges.
- READY:
  - Key handshake re-expands (back to EXPAND), replacing the old key.
  - Ciphertext handshake: dreg<=in, rc<=18, go to RUN.
- RUN (exactly 19 cycles):
  - Each cycle: dreg<=inv(dreg, RK[rc]), rc<=rc-1.
  - On the rc==0 cycle, out<=inv(dreg, RK[0]) and out_valid<=1; go to DONE.
  - Latency: the ciphertext handshake edge is e0; out_valid is first high after edge e0+19.
- DONE:
  - out and out_valid hold stable until out_ready.
  - On out_valid & out_ready: out_valid<=0, go to READY. out keeps its last value.
  - No key or ciphertext is accepted in DONE.
  - out_ready asserted while out_valid=0 has no effect.
- Back-to-back throughput: one block per 21 cycles with out_ready tied high (19 RUN + 1 DONE + 1 READY accept).
- Key persists across any number of blocks until a new key is accepted or reset.
- Reset mid-EXPAND, RUN or DONE:
  - Immediate return to NOKEY with out_valid=0.
  - Any partial result is discarded and the key must be reloaded.
- Valid inputs are sampled only at handshake edges. Changes to key or in outside a handshake have no effect on state.

Test Plan:
1. Reset, then key=128'h0, wait key_ready, in=ENC(0,0) from sonic_encrypt_64x128 -> out=64'h0; out_valid rises exactly 19 edges after the in handshake; busy high 9 cycles during EXPAND.
2. key=128'h0123456789ABCDEF_FEDCBA9876543210, 8 random plaintexts P encrypted by the reference encryptor, fed back-to-back with out_ready=1 -> out equals each P in order, 21-cycle spacing.
3. out_ready held low 50 cycles in DONE -> out and out_valid stable throughout; in_ready=0 and key_ready=0; release -> single transfer, then READY.
4. key_valid and in_valid high together in READY -> key accepted, in not accepted (in_ready=0); the next ciphertext decrypts under the new key.
5. resetn pulsed low asynchronously mid-RUN (rc=7) and mid-EXPAND (j=4) -> outputs go to reset values without a clock edge; state NOKEY; in_valid is ignored until a new key completes expansion.
6. Key change between blocks (K_a, then K_b) -> the first block decrypts under K_a and the second under K_b, each matching its reference plaintext.
